// File: rtl/dcp_window_min.sv
// -----------------------------------------------------------------------------
// dcp_window_min
//   Streaming 3x3 spatial minimum (dark channel) for the Dark Channel Prior
//   path. Consumes one channel-minimum byte per pixel in raster order and
//   emits one window minimum per pixel. Out-of-frame neighbours read as 8'hFF.
//
//   Parameters : IMG_W (pixels per line, >= 3), IMG_H (lines per frame, >= 2)
//   Ports      : i_clk, i_rst (sync, active high)
//                i_valid/i_data  - input pixel stream, taken when o_ready
//                o_ready         - low while the frame tail is being flushed
//                o_valid/o_dark  - registered window minimum, one per pixel
//                o_sof/o_eof     - first / last centre of the frame
//   Optional   : `define DCP_DARK_MAX_EN adds o_dark_max/o_max_valid, the
//                per-frame maximum of o_dark, pulsed the cycle after o_eof.
// -----------------------------------------------------------------------------
module dcp_window_min #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_valid,
   output logic [7:0] o_dark,
   output logic       o_sof,
   output logic       o_eof
`ifdef DCP_DARK_MAX_EN
   ,
   output logic [7:0] o_dark_max,
   output logic       o_max_valid
`endif
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int PMAX = NPIX + IMG_W;        // last stream index of a frame
   localparam int PW   = $clog2(PMAX + 1);
   localparam int XW   = $clog2(IMG_W);
   localparam int YW   = $clog2(IMG_H);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   p_q, p_d;                 // stream (advance) index
   logic [XW-1:0]   x_q, x_d;                 // column of the incoming advance
   logic [XW-1:0]   cx_q, cx_d;               // next centre to emit
   logic [YW-1:0]   cy_q, cy_d;

   logic            valid_q, sof_q, eof_q;
   logic [7:0]      dark_q;

   // Row buffers: lb1 holds the previous line, lb2 the one before that.
   logic [7:0]      lb1_q [IMG_W];
   logic [7:0]      lb2_q [IMG_W];
   // Window: two registered columns (cx-1, cx); the cx+1 column is the live
   // column formed from the row buffers and the incoming byte.
   logic [7:0]      win_q [3][2];
   logic [7:0]      newcol [3];
   logic [7:0]      nb [3][3];
   logic [2:0]      row_ok, col_ok;

   logic            adv, produce;
   logic [7:0]      din, min_d;

   assign o_ready = (state_q != FLUSH);
   assign adv     = (state_q == FLUSH) || (i_valid && o_ready);
   assign din     = (state_q == FLUSH) ? 8'hFF : i_data;
   assign produce = adv && (p_q >= PW'(IMG_W + 1));

   // Live column: rows cy-1, cy, cy+1 of column cx+1.
   assign newcol[0] = lb2_q[x_q];
   assign newcol[1] = lb1_q[x_q];
   assign newcol[2] = din;

   // Edge masks keep stale buffer contents and the neighbouring line's ends
   // out of the minimum.
   assign row_ok = {cy_q != YW'(IMG_H - 1), 1'b1, cy_q != '0};
   assign col_ok = {cx_q != XW'(IMG_W - 1), 1'b1, cx_q != '0};

   always_comb begin
      min_d = 8'hFF;
      for (int r = 0; r < 3; r++) begin
         nb[r][0] = win_q[r][0];
         nb[r][1] = win_q[r][1];
         nb[r][2] = newcol[r];
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (row_ok[r] && col_ok[c] && (nb[r][c] < min_d)) min_d = nb[r][c];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      x_d     = x_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      if (adv) begin
         p_d = p_q + 1'b1;
         x_d = (x_q == XW'(IMG_W - 1)) ? '0 : x_q + 1'b1;
      end
      if (produce) begin
         if (cx_q == XW'(IMG_W - 1)) begin
            cx_d = '0;
            cy_d = (cy_q == YW'(IMG_H - 1)) ? '0 : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
      end
      case (state_q)
         IDLE, RUN: begin
            if (adv) state_d = (p_q == PW'(NPIX - 1)) ? FLUSH : RUN;
         end
         FLUSH: begin
            if (p_q == PW'(PMAX)) begin
               state_d = IDLE;
               p_d     = '0;
               x_d     = '0;
               cx_d    = '0;
               cy_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         x_q     <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         valid_q <= 1'b0;
         dark_q  <= '0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         x_q     <= x_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         valid_q <= produce;
         sof_q   <= produce && (cx_q == '0) && (cy_q == '0);
         eof_q   <= produce && (p_q == PW'(PMAX));
         if (produce) dark_q <= min_d;
      end
   end

   // Data storage needs no reset: every stale read is masked above.
   always_ff @(posedge i_clk) begin
      if (adv) begin
         lb2_q[x_q] <= lb1_q[x_q];
         lb1_q[x_q] <= din;
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= newcol[r];
         end
      end
   end

   assign o_valid = valid_q;
   assign o_dark  = dark_q;
   assign o_sof   = sof_q;
   assign o_eof   = eof_q;

`ifdef DCP_DARK_MAX_EN
   logic [7:0] run_max_q, dark_max_q, frame_max;
   logic       max_valid_q;

   // The sof output restarts the running maximum.
   assign frame_max = (sof_q || (dark_q > run_max_q)) ? dark_q : run_max_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         run_max_q   <= '0;
         dark_max_q  <= '0;
         max_valid_q <= 1'b0;
      end else begin
         max_valid_q <= valid_q && eof_q;
         if (valid_q)          run_max_q  <= frame_max;
         if (valid_q && eof_q) dark_max_q <= frame_max;
      end
   end

   assign o_dark_max  = dark_max_q;
   assign o_max_valid = max_valid_q;
`else
   // Frame statistics not built.
`endif

endmodule
